// File: rtl/ecc_pkg.sv
// Shared types for the ECC scrub engine: codeword layout and scrub FSM states.
package ecc_pkg;
  localparam int CW_W   = 39;
  localparam int DATA_W = 32;

  typedef logic [CW_W-1:0] codeword_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_DEC,
    S_WB,
    S_NEXT,
    S_FIN
  } scrub_state_e;
endpackage

// File: rtl/ecc_scrubber_if.sv
// Memory port plus the decoder side-channel, as seen from the scrubber (master).
interface ecc_scrubber_if import ecc_pkg::*; #(
  parameter int ADDR_W = 10
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  codeword_t         mem_wdata;
  codeword_t         mem_rdata;
  logic              mem_ack;
  codeword_t         dec_in;
  codeword_t         dec_out;
  logic              dec_err;
  logic              dec_sgl;
  logic              dec_dbl;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, dec_in,
    input  mem_rdata, mem_ack, dec_out, dec_err, dec_sgl, dec_dbl
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, dec_in,
    output mem_rdata, mem_ack, dec_out, dec_err, dec_sgl, dec_dbl
  );
endinterface

// File: rtl/sat_counter.sv
// Counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (inc && ~&cnt_q) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/ecc_scrubber.sv
// Background scrubber: reads each word of a window through the SECDED decoder,
// writes back corrected single-bit errors and logs uncorrectable addresses.
module ecc_scrubber import ecc_pkg::*; #(
  parameter int ADDR_W  = 10,
  parameter int DEC_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_last,
  ecc_scrubber_if.master      bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sgl_cnt,
  output logic [CNT_W-1:0]    dbl_cnt,
  output logic                dbl_valid,
  output logic [ADDR_W-1:0]   dbl_addr
);
  localparam int LAT_W = $clog2(DEC_LAT + 1);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              abort_q, abort_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  codeword_t         mem_wdata_q, mem_wdata_d;
  codeword_t         dec_in_q, dec_in_d;
  logic              busy_q, busy_d;
  logic              dbl_valid_q, dbl_valid_d;
  logic [ADDR_W-1:0] dbl_addr_q, dbl_addr_d;
  logic              cnt_clr, sgl_inc, dbl_inc;
  logic              is_dbl;

  // Any flag pattern that is not a clean single-bit correction is uncorrectable.
  assign is_dbl = bus.dec_dbl || (bus.dec_err && !bus.dec_sgl);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    abort_d     = abort_q;
    lat_d       = lat_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    dec_in_d    = dec_in_q;
    busy_d      = busy_q;
    dbl_valid_d = 1'b0;
    dbl_addr_d  = dbl_addr_q;
    cnt_clr     = 1'b0;
    sgl_inc     = 1'b0;
    dbl_inc     = 1'b0;

    if (state_q != S_IDLE && abort) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = cfg_base;
          last_d  = cfg_last;
          cnt_clr = 1'b1;
          busy_d  = 1'b1;
          if (cfg_base > cfg_last) begin
            state_d = S_FIN;
          end else begin
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
            state_d   = S_RD;
          end
        end
      end
      S_RD: begin
        if (bus.mem_ack) begin
          dec_in_d  = bus.mem_rdata;
          mem_req_d = 1'b0;
          lat_d     = LAT_W'(DEC_LAT);
          state_d   = S_DEC;
        end
      end
      S_DEC: begin
        if (lat_q > LAT_W'(1)) begin
          lat_d = lat_q - 1'b1;
        end else if (is_dbl) begin
          dbl_inc     = 1'b1;
          dbl_addr_d  = addr_q;
          dbl_valid_d = 1'b1;
          state_d     = S_NEXT;
        end else if (bus.dec_sgl) begin
          sgl_inc     = 1'b1;
          mem_wdata_d = bus.dec_out;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          state_d     = S_WB;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WB: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_NEXT;
        end
      end
      S_NEXT: begin
        if (addr_q == last_q || abort_q || abort) begin
          state_d = S_FIN;
        end else begin
          addr_d    = addr_q + 1'b1;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          state_d   = S_RD;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      abort_q     <= 1'b0;
      lat_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      dec_in_q    <= '0;
      busy_q      <= 1'b0;
      dbl_valid_q <= 1'b0;
      dbl_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      abort_q     <= abort_d;
      lat_q       <= lat_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      dec_in_q    <= dec_in_d;
      busy_q      <= busy_d;
      dbl_valid_q <= dbl_valid_d;
      dbl_addr_q  <= dbl_addr_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_sgl_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (sgl_inc),
    .q   (sgl_cnt)
  );

  sat_counter #(.W(CNT_W)) u_dbl_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (dbl_inc),
    .q   (dbl_cnt)
  );

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.dec_in    = dec_in_q;
  assign busy          = busy_q;
  assign done          = (state_q == S_FIN);
  assign dbl_valid     = dbl_valid_q;
  assign dbl_addr      = dbl_addr_q;
endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed + randomized bench: Hamming SECDED memory model, pass-level reference model.
module tb_ecc_scrubber;
  import ecc_pkg::*;

  localparam int AW  = 10;
  localparam int LAT = 1;
  localparam int CWD = 2;
  localparam int LIM = 2000;
  localparam int SATV = (1 << CWD) - 1;

  typedef struct packed {
    codeword_t fix;
    logic      e;
    logic      s;
    logic      d;
  } dres_t;

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [AW-1:0]   cfg_base, cfg_last;
  logic            busy, done, dbl_valid;
  logic [CWD-1:0]  sgl_cnt, dbl_cnt;
  logic [AW-1:0]   dbl_addr;

  always #5 clk = ~clk;

  ecc_scrubber_if #(.ADDR_W(AW)) bus ();

  ecc_scrubber #(.ADDR_W(AW), .DEC_LAT(LAT), .CNT_W(CWD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_base  (cfg_base),
    .cfg_last  (cfg_last),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .sgl_cnt   (sgl_cnt),
    .dbl_cnt   (dbl_cnt),
    .dbl_valid (dbl_valid),
    .dbl_addr  (dbl_addr)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- SECDED reference: Hamming positions 1..38, bit 0 = overall parity
  function automatic codeword_t encode(logic [31:0] d);
    codeword_t c = '0;
    int k = 0;
    logic x;
    for (int i = 1; i < 39; i++)
      if ((i & (i - 1)) != 0) begin c[i] = d[k]; k++; end
    for (int p = 0; p < 6; p++) begin
      x = 1'b0;
      for (int i = 1; i < 39; i++)
        if (((i >> p) & 1) == 1 && i != (1 << p)) x ^= c[i];
      c[1 << p] = x;
    end
    c[0] = ^c[38:1];
    return c;
  endfunction

  function automatic dres_t decode(codeword_t cw);
    dres_t r;
    int s = 0;
    logic ov;
    ov = ^cw;
    for (int i = 1; i < 39; i++) if (cw[i]) s ^= i;
    r.fix = cw;
    r.e = (s != 0) || ov;
    r.s = 1'b0;
    r.d = 1'b0;
    if (ov) begin
      if (s < 39) begin r.fix[s] = ~cw[s]; r.s = 1'b1; end
      else r.d = 1'b1;
    end else if (s != 0) begin
      r.d = 1'b1;
    end
    return r;
  endfunction

  function automatic int sat(int x);
    return (x > SATV) ? SATV : x;
  endfunction

  // ---------------- decoder model (DEC_LAT=1: valid in the cycle after dec_in updates)
  int ovr = 0;
  always_comb begin
    dres_t r;
    r = decode(bus.dec_in);
    bus.dec_out = r.fix;
    bus.dec_err = r.e;
    bus.dec_sgl = r.s;
    bus.dec_dbl = r.d;
    if (ovr == 1) begin
      bus.dec_err = 1'b1; bus.dec_sgl = 1'b0; bus.dec_dbl = 1'b0;
    end else if (ovr == 2) begin
      bus.dec_err = 1'b1; bus.dec_sgl = 1'b1; bus.dec_dbl = 1'b1;
    end
  end

  // ---------------- memory model with backdoor port
  codeword_t mem  [0:1023];
  codeword_t gold [0:63];
  codeword_t snap [0:1023];
  int        rd_log[$];
  int        wr_a[$];
  codeword_t wr_d[$];
  int        ack_dly = 0;
  int        wcnt;
  bit        ack_block = 1'b0;
  logic      bd_we = 1'b0;
  int        bd_addr;
  codeword_t bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (rst) begin
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= '0;
      wcnt          <= 0;
    end else if (bus.mem_req && !bus.mem_ack && !(ack_block && bus.mem_we)) begin
      if (wcnt >= ack_dly) begin
        bus.mem_ack <= 1'b1;
        wcnt        <= 0;
        if (bus.mem_we) begin
          mem[bus.mem_addr] <= bus.mem_wdata;
          wr_a.push_back(int'(bus.mem_addr));
          wr_d.push_back(bus.mem_wdata);
        end else begin
          bus.mem_rdata <= mem[bus.mem_addr];
          rd_log.push_back(int'(bus.mem_addr));
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      bus.mem_ack <= 1'b0;
    end
  end

  int done_cnt = 0;
  int dblv_cnt = 0;
  always @(posedge clk) begin
    if (!rst && done)      done_cnt <= done_cnt + 1;
    if (!rst && dbl_valid) dblv_cnt <= dblv_cnt + 1;
  end

  // ---------------- helpers
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(int a, codeword_t d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  int done0, dblv0, exp_dbl;

  task automatic start_pass(int b, int l);
    for (int i = 0; i < 1024; i++) snap[i] = mem[i];
    rd_log.delete(); wr_a.delete(); wr_d.delete();
    done0 = done_cnt; dblv0 = dblv_cnt;
    @(negedge clk);
    cfg_base = AW'(b); cfg_last = AW'(l); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string tag, output int n);
    n = 0;
    while (done !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk({tag, ".timeout"}, 64'(n < LIM), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Expected outcome of a pass over snap[base..stop], computed from the scrub rules.
  task automatic check_pass(string tag, int base, int stop);
    int n_s = 0, n_d = 0;
    int ea[$];
    codeword_t ed[$];
    dres_t r;
    for (int a = base; a <= stop; a++) begin
      r = decode(snap[a]);
      if (ovr != 0 || r.d) begin n_d++; exp_dbl = a; end
      else if (r.s) begin n_s++; ea.push_back(a); ed.push_back(r.fix); end
    end
    chk({tag, ".nrd"}, 64'(rd_log.size()), 64'(stop - base + 1));
    for (int i = 0; i < rd_log.size() && i <= stop - base; i++)
      chk({tag, ".rdaddr"}, 64'(rd_log[i]), 64'(base + i));
    chk({tag, ".nwr"}, 64'(wr_a.size()), 64'(ea.size()));
    for (int i = 0; i < wr_a.size() && i < ea.size(); i++) begin
      chk({tag, ".wraddr"}, 64'(wr_a[i]), 64'(ea[i]));
      chk({tag, ".wrdata"}, 64'(wr_d[i]), 64'(ed[i]));
    end
    chk({tag, ".sgl_cnt"}, 64'(sgl_cnt), 64'(sat(n_s)));
    chk({tag, ".dbl_cnt"}, 64'(dbl_cnt), 64'(sat(n_d)));
    chk({tag, ".dbl_pulses"}, 64'(dblv_cnt - dblv0), 64'(n_d));
    chk({tag, ".dbl_addr"}, 64'(dbl_addr), 64'(exp_dbl));
    chk({tag, ".done_pulses"}, 64'(done_cnt - done0), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run(string tag, int b, int l);
    int n;
    start_pass(b, l);
    wait_done(tag, n);
    check_pass(tag, b, (b > l) ? b - 1 : l);
  endtask

  // ---------------- directed sequence
  initial begin
    int n, b, len, m, b1, b2;
    codeword_t cw;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_base = '0; cfg_last = '0;
    exp_dbl = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.mem_req",   64'(bus.mem_req),   64'd0);
    chk("rst.mem_we",    64'(bus.mem_we),    64'd0);
    chk("rst.mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("rst.mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst.dec_in",    64'(bus.dec_in),    64'd0);
    chk("rst.busy",      64'(busy),          64'd0);
    chk("rst.done",      64'(done),          64'd0);
    chk("rst.sgl_cnt",   64'(sgl_cnt),       64'd0);
    chk("rst.dbl_cnt",   64'(dbl_cnt),       64'd0);
    chk("rst.dbl_valid", 64'(dbl_valid),     64'd0);
    chk("rst.dbl_addr",  64'(dbl_addr),      64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      gold[i] = encode($urandom);
      poke(i, gold[i]);
    end

    // clean window
    run("clean", 0, 3);

    // single-bit error at word 2, then a re-scrub sees it fixed
    cw = gold[2]; cw[5] = ~cw[5];
    poke(2, cw);
    run("sgl", 0, 3);
    chk("sgl.mem2_fixed", 64'(mem[2]), 64'(gold[2]));
    run("sgl.rescrub", 0, 3);

    // double-bit error at word 1
    cw = gold[1]; cw[3] = ~cw[3]; cw[17] = ~cw[17];
    poke(1, cw);
    run("dbl", 0, 3);
    chk("dbl.addr1", 64'(dbl_addr), 64'd1);
    poke(1, gold[1]);

    // abort while the read of word 5 is waiting for its ack
    ack_dly = 3;
    start_pass(4, 9);
    n = 0;
    while (!(bus.mem_req && !bus.mem_we && bus.mem_addr == AW'(5)) && n < LIM) begin
      @(negedge clk); n++;
    end
    chk("abort.reach5", 64'(n < LIM), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort", n);
    check_pass("abort", 4, 5);
    ack_dly = 0;

    // reset in the middle of a write-back that never gets acked
    cw = gold[0]; cw[9] = ~cw[9];
    poke(0, cw);
    ack_block = 1'b1;
    start_pass(0, 3);
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < LIM) begin @(negedge clk); n++; end
    chk("rstwb.reach", 64'(n < LIM), 64'd1);
    chk("rstwb.pre_sgl", 64'(sgl_cnt), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstwb.mem_req", 64'(bus.mem_req), 64'd0);
    chk("rstwb.busy",    64'(busy),        64'd0);
    chk("rstwb.sgl_cnt", 64'(sgl_cnt),     64'd0);
    chk("rstwb.dbl_cnt", 64'(dbl_cnt),     64'd0);
    chk("rstwb.dbl_addr", 64'(dbl_addr),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_block = 1'b0;
    exp_dbl = 0;
    repeat (3) @(negedge clk);
    chk("rstwb.nowrite", 64'(wr_a.size()), 64'd0);
    run("rstwb.after", 0, 3);

    // inverted window: no memory traffic, done almost immediately
    start_pass(7, 3);
    wait_done("inv", n);
    chk("inv.latency", 64'(n <= 1), 64'd1);
    check_pass("inv", 7, 6);

    // five single-bit errors saturate a 2-bit counter
    for (int a = 10; a < 15; a++) begin
      cw = gold[a]; cw[a] = ~cw[a];
      poke(a, cw);
    end
    run("sat", 10, 14);
    chk("sat.value", 64'(sgl_cnt), 64'(SATV));

    // odd flag combinations count as uncorrectable
    ovr = 1;
    run("err_only", 20, 21);
    ovr = 2;
    run("sgl_dbl", 22, 22);
    ovr = 0;

    // randomized windows
    for (int it = 0; it < 4; it++) begin
      b   = $urandom_range(30, 50);
      len = $urandom_range(0, 6);
      for (int a = b; a <= b + len; a++) begin
        cw = gold[a];
        m  = $urandom_range(0, 3);
        b1 = $urandom_range(0, 38);
        b2 = (b1 + 1 + $urandom_range(0, 37)) % 39;
        if (m >= 1) cw[b1] = ~cw[b1];
        if (m == 2) cw[b2] = ~cw[b2];
        poke(a, cw);
      end
      ack_dly = $urandom_range(0, 2);
      run("rand", b, b + len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
